// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter that shares the ping-pong buffer write port between N_CH sources,
// granting whole BURST-word bursts and zero-padding a burst whose source stalls too long.
module ram_write_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned CH_W   = $clog2(N_CH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH*WIDTH-1:0] ch_data_i,
    input  logic [N_CH-1:0]       ch_valid_i,
    output logic [N_CH-1:0]       ch_ready_o,
    output logic [WIDTH-1:0]      ram_data_o,
    output logic                  ram_valid_o,
    input  logic                  ram_ready_i,
    input  logic                  ram_frame_i,
    output logic [CH_W-1:0]       grant_ch_o,
    output logic                  grant_active_o,
    output logic                  burst_done_o,
    output logic                  pad_o,
    output logic [15:0]           frame_count_o
);

    localparam int unsigned BEAT_W = $clog2(BURST + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StPad} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              burst_done_q, burst_done_d;
    logic [15:0]       frame_q;

    logic [WIDTH-1:0]  ch_words [N_CH];
    logic [CH_W-1:0]   next_ch;
    logic [CH_W-1:0]   idx_ch;
    logic              found;
    logic              beat;
    logic              last_beat;

    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            ch_words[c] = ch_data_i[c*WIDTH +: WIDTH];
        end
    end

    // First requester after the previously served channel, wrapping modulo N_CH.
    always_comb begin
        next_ch = last_ch_q;
        found   = 1'b0;
        idx_ch  = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx_ch = CH_W'((32'(last_ch_q) + i) % N_CH);
            if (!found && ch_valid_i[idx_ch]) begin
                found   = 1'b1;
                next_ch = idx_ch;
            end
        end
    end

    always_comb begin
        ram_valid_o    = 1'b0;
        ram_data_o     = '0;
        ch_ready_o     = '0;
        pad_o          = 1'b0;
        grant_active_o = 1'b0;
        unique case (state_q)
            StBusy: begin
                ram_valid_o         = ch_valid_i[grant_q];
                ram_data_o          = ch_words[grant_q];
                ch_ready_o[grant_q] = ram_ready_i;
                grant_active_o      = 1'b1;
            end
            StPad: begin
                ram_valid_o    = 1'b1;
                pad_o          = 1'b1;
                grant_active_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign beat      = ram_valid_o && ram_ready_i;
    assign last_beat = (beat_q == BEAT_W'(BURST - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_ch_d    = last_ch_q;
        beat_d       = beat_q;
        idle_d       = idle_q;
        burst_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = next_ch;
                    beat_d  = '0;
                    idle_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy, StPad: begin
                if (beat) begin
                    idle_d = '0;
                    if (last_beat) begin
                        beat_d       = '0;
                        last_ch_d    = grant_q;
                        burst_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (state_q == StBusy && ram_ready_i && !ch_valid_i[grant_q]) begin
                    // Idle cycles only count while the buffer could have accepted a word.
                    if (idle_q < IDLE_W'(TIMEOUT)) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                    if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
                        state_d = StPad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_ch_q    <= CH_W'(N_CH - 1);
            beat_q       <= '0;
            idle_q       <= '0;
            burst_done_q <= 1'b0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_ch_q    <= last_ch_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
            burst_done_q <= burst_done_d;
            if (ram_frame_i) begin
                frame_q <= frame_q + 16'd1;
            end
        end
    end

    assign grant_ch_o    = grant_q;
    assign burst_done_o  = burst_done_q;
    assign frame_count_o = frame_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter: sources emit {channel, sequence} words and a queue
// of expected beats is compared against every buffer-side transfer.
module tb_ram_write_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_CH  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] ch_data;
    logic [N_CH-1:0]       ch_valid;
    logic [N_CH-1:0]       ch_ready;
    logic [WIDTH-1:0]      ram_data;
    logic                  ram_valid;
    logic                  ram_ready;
    logic                  ram_frame;
    logic [1:0]            grant_ch;
    logic                  grant_active;
    logic                  burst_done;
    logic                  pad;
    logic [15:0]           frame_count;

    typedef struct packed {
        logic [31:0] data;
        logic        pad;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [23:0] seq     [N_CH] = '{default: 24'd0};
    logic [23:0] exp_seq [N_CH] = '{default: 24'd0};
    int          n_pass = 0;
    int          n_total = 0;

    ram_write_arbiter #(
        .WIDTH  (WIDTH),
        .N_CH   (N_CH),
        .BURST  (4),
        .TIMEOUT(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ch_data_i     (ch_data),
        .ch_valid_i    (ch_valid),
        .ch_ready_o    (ch_ready),
        .ram_data_o    (ram_data),
        .ram_valid_o   (ram_valid),
        .ram_ready_i   (ram_ready),
        .ram_frame_i   (ram_frame),
        .grant_ch_o    (grant_ch),
        .grant_active_o(grant_active),
        .burst_done_o  (burst_done),
        .pad_o         (pad),
        .frame_count_o (frame_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ch_data[c*WIDTH +: WIDTH] = {8'(c), seq[c]};
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (!rst && ch_valid[c] && ch_ready[c]) seq[c] <= seq[c] + 24'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic push_burst(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{data: {8'(c), exp_seq[c]}, pad: 1'b0});
            exp_seq[c] = exp_seq[c] + 24'd1;
        end
    endtask

    task automatic push_pad(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: 32'd0, pad: 1'b1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = burst_done;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Scoreboard and ungranted-ready monitor.
    always @(negedge clk) begin
        if (ram_valid && ram_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", ram_data, mon_e.data);
                chk("beat_pad", 32'(pad), 32'(mon_e.pad));
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (c != int'(grant_ch)) chk("ungranted_ready", 32'(ch_ready[c]), 32'd0);
        end
    end

    initial begin
        rst = 1'b1; ch_valid = '0; ram_ready = 1'b1; ram_frame = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_grant", 32'(grant_ch), 32'd0);
        chk("rst_active", 32'(grant_active), 32'd0);
        chk("rst_valid", 32'(ram_valid), 32'd0);
        chk("rst_done", 32'(burst_done), 32'd0);
        chk("rst_frame", 32'(frame_count), 32'd0);
        tick();
        rst = 1'b0;

        // Single requester: back-to-back bursts separated by one arbitration cycle.
        tick();
        push_burst(1, 8);
        ch_valid = 4'b0010;
        @(negedge clk);
        chk("t1_arb_cycle", 32'(grant_active), 32'd0);
        @(negedge clk);
        chk("t1_grant", 32'(grant_ch), 32'd1);
        chk("t1_active", 32'(grant_active), 32'd1);
        wait_done("t1_done1");
        chk("t1_bubble", 32'(grant_active), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(burst_done), 32'd0);
        chk("t1_regrant", 32'(grant_ch), 32'd1);
        chk("t1_reactive", 32'(grant_active), 32'd1);
        wait_done("t1_done2");
        ch_valid = '0;

        // All channels requesting: strict round robin from channel 0.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_burst(0, 4); push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4);
        tick();
        ch_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done("t2_done");
            chk("t2_order", 32'(grant_ch), 32'(k % 4));
        end
        ch_valid = '0;

        // Channel 2 stalls after two beats: two zero pad words close the burst.
        tick();
        push_burst(2, 2);
        push_pad(2);
        ch_valid = 4'b0100;
        tick(); tick(); tick();
        ch_valid = '0;
        for (int i = 0; i < 9; i++) tick();
        ch_valid = 4'b0100;
        @(negedge clk);
        chk("t3_pad", 32'(pad), 32'd1);
        chk("t3_pad_ready", 32'(ch_ready), 32'd0);
        chk("t3_pad_data", ram_data, 32'd0);
        chk("t3_pad_valid", 32'(ram_valid), 32'd1);
        wait_done("t3_done");
        chk("t3_pad_end", 32'(pad), 32'd0);
        ch_valid = '0;

        // Buffer back-pressure mid-burst: nothing advances, no padding.
        tick();
        push_burst(3, 4);
        ch_valid = 4'b1000;
        tick(); tick();
        ram_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(ram_valid), 32'd1);
            chk("t4_hold_data", ram_data, exp_q[0].data);
            chk("t4_no_pad", 32'(pad), 32'd0);
        end
        tick();
        ram_ready = 1'b1;
        wait_done("t4_done");
        ch_valid = '0;

        // Reset in the middle of a burst.
        tick();
        ram_frame = 1'b1;
        tick(); tick(); tick();
        ram_frame = 1'b0;
        push_burst(0, 2);
        ch_valid = 4'b0001;
        tick(); tick(); tick();
        chk("t5_frames", 32'(frame_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(ram_valid), 32'd0);
        chk("t5_async_active", 32'(grant_active), 32'd0);
        chk("t5_async_ready", 32'(ch_ready), 32'd0);
        chk("t5_async_frame", 32'(frame_count), 32'd0);
        tick();
        ch_valid = 4'b1111;
        tick();
        rst = 1'b0;
        push_burst(0, 4);
        tick();
        @(negedge clk);
        chk("t5_grant0", 32'(grant_ch), 32'd0);
        chk("t5_active", 32'(grant_active), 32'd1);
        wait_done("t5_done");
        ch_valid = '0;

        // Frame counter wrap.
        tick();
        ram_frame = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        chk("t6_frame_max", 32'(frame_count), 32'h0000_FFFF);
        tick();
        ram_frame = 1'b0;
        chk("t6_frame_wrap", 32'(frame_count), 32'd0);

        tick(); tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
